// File: rtl/shift_arbiter.sv
// Four-way round-robin arbiter that sequences an external shifter through
// load, execute and capture phases, and returns each result to its requester.
module shift_arbiter #(
  parameter int unsigned LOAD_CYCLES = 2,
  parameter int unsigned EXEC_CYCLES = 3
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  req_valid,
  output logic [3:0]  req_ready,
  input  logic [63:0] req_data,
  input  logic [11:0] req_coeff,
  input  logic [7:0]  req_dir,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic [1:0]  resp_id,
  output logic        resp_bypass,
  output logic        sh_enable,
  output logic        sh_write,
  output logic [1:0]  sh_direction,
  output logic [15:0] sh_input,
  output logic [2:0]  sh_coeff,
  input  logic [15:0] sh_result,
  output logic        busy
);

  typedef enum logic [2:0] {StIdle, StLoad, StExec, StCapture, StResp} state_e;

  state_e      state_q;
  logic [1:0]  ptr_q;
  logic [1:0]  id_q;
  logic [3:0]  cnt_q;

  logic        grant_found;
  logic [1:0]  grant_id;
  logic [1:0]  idx;
  logic        accept;
  logic [15:0] sel_data;
  logic [2:0]  sel_coeff;
  logic [1:0]  sel_dir;

  // Round-robin search starting at ptr_q; first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = ptr_q;
    idx         = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx;
      end
    end
    req_ready = '0;
    if (aresetn && (state_q == StIdle) && grant_found) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign accept    = (state_q == StIdle) && grant_found;
  assign sel_data  = req_data[16*int'(grant_id) +: 16];
  assign sel_coeff = req_coeff[3*int'(grant_id) +: 3];
  assign sel_dir   = req_dir[2*int'(grant_id) +: 2];
  assign busy      = (state_q != StIdle);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      id_q         <= '0;
      cnt_q        <= '0;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      resp_id      <= '0;
      resp_bypass  <= 1'b0;
      sh_enable    <= 1'b0;
      sh_write     <= 1'b0;
      sh_direction <= '0;
      sh_input     <= '0;
      sh_coeff     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            ptr_q <= grant_id + 2'd1;
            id_q  <= grant_id;
            cnt_q <= '0;
            // Only 2'b10 and 2'b01 are real shifts; the other codes bypass.
            if (^sel_dir) begin
              state_q      <= StLoad;
              sh_enable    <= 1'b1;
              sh_write     <= 1'b1;
              sh_input     <= sel_data;
              sh_coeff     <= sel_coeff;
              sh_direction <= sel_dir;
            end else begin
              state_q     <= StResp;
              resp_valid  <= 1'b1;
              resp_data   <= sel_data;
              resp_id     <= grant_id;
              resp_bypass <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (cnt_q == 4'(LOAD_CYCLES - 1)) begin
            state_q  <= StExec;
            cnt_q    <= '0;
            sh_write <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StExec: begin
          if (cnt_q == 4'(EXEC_CYCLES - 1)) begin
            state_q <= StCapture;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StCapture: begin
          state_q     <= StResp;
          cnt_q       <= '0;
          sh_enable   <= 1'b0;
          resp_valid  <= 1'b1;
          resp_data   <= sh_result;
          resp_id     <= id_q;
          resp_bypass <= 1'b0;
        end
        StResp: begin
          if (resp_ready) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            resp_valid <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: arbitration order, shift/bypass timing,
// back-pressure and mid-transaction reset, with a rotating shifter model.
module tb_shift_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_data;
  logic [11:0] req_coeff;
  logic [7:0]  req_dir;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic [1:0]  resp_id;
  logic        resp_bypass;
  logic        sh_enable;
  logic        sh_write;
  logic [1:0]  sh_direction;
  logic [15:0] sh_input;
  logic [2:0]  sh_coeff;
  logic [15:0] sh_result;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 aclk = ~aclk;

  shift_arbiter dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .req_coeff    (req_coeff),
    .req_dir      (req_dir),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_id      (resp_id),
    .resp_bypass  (resp_bypass),
    .sh_enable    (sh_enable),
    .sh_write     (sh_write),
    .sh_direction (sh_direction),
    .sh_input     (sh_input),
    .sh_coeff     (sh_coeff),
    .sh_result    (sh_result),
    .busy         (busy)
  );

  // Shifter model: rotate left for 2'b10, rotate right for 2'b01.
  logic [31:0] rot_tmp;
  always_comb begin
    rot_tmp   = '0;
    sh_result = sh_input;
    if (sh_direction == 2'b10) begin
      rot_tmp   = {sh_input, sh_input} << sh_coeff;
      sh_result = rot_tmp[31:16];
    end else if (sh_direction == 2'b01) begin
      rot_tmp   = {sh_input, sh_input} >> sh_coeff;
      sh_result = rot_tmp[15:0];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [15:0] d, input logic [2:0] c,
                         input logic [1:0] dir);
    req_data[16*id +: 16] = d;
    req_coeff[3*id +: 3]  = c;
    req_dir[2*id +: 2]    = dir;
  endtask

  // Returns just after the accepting clock edge.
  task automatic wait_grant(input string tag, input logic [1:0] exp_id);
    int n = 0;
    @(negedge aclk);
    while (!(|(req_ready & req_valid)) && n < 30) begin
      @(negedge aclk);
      n++;
    end
    check({tag, "_grant"}, 32'(req_ready), 32'(4'b0001 << exp_id));
    @(posedge aclk);
    #1;
  endtask

  // Latency counts the accept cycle as cycle 1; returns at the negedge where
  // resp_valid is first seen.
  task automatic wait_resp(input string tag, input logic [15:0] exp_data,
                           input logic [1:0] exp_id, input logic exp_byp,
                           input int exp_lat, input int exp_en, input int exp_wr);
    int lat = 1;
    int en  = 0;
    int wr  = 0;
    @(negedge aclk);
    while (!resp_valid && lat < 40) begin
      if (sh_enable) en++;
      if (sh_write) wr++;
      @(negedge aclk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_en_cycles"}, 32'(en), 32'(exp_en));
    check({tag, "_wr_cycles"}, 32'(wr), 32'(exp_wr));
    check({tag, "_data"}, 32'(resp_data), 32'(exp_data));
    check({tag, "_id"}, 32'(resp_id), 32'(exp_id));
    check({tag, "_bypass"}, 32'(resp_bypass), 32'(exp_byp));
    check({tag, "_no_ready"}, 32'(req_ready), 32'h0);
  endtask

  logic [1:0]  rr_id   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [15:0] rr_data [5] = '{16'h0001, 16'h1111, 16'h0780, 16'hCAFE, 16'h0001};
  logic        rr_byp  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    aresetn    = 1'b0;
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    req_data   = '0;
    req_coeff  = '0;
    req_dir    = '0;
    #12;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_sh_enable", 32'(sh_enable), 32'h0);
    req_valid = '0;
    @(posedge aclk);
    #1 aresetn = 1'b1;

    // Left rotate by 1 through the full load/exec/capture sequence.
    set_req(0, 16'h8001, 3'd1, 2'b10);
    req_valid = 4'b0001;
    wait_grant("shift0", 2'd0);
    req_valid = '0;
    wait_resp("shift0", 16'h0003, 2'd0, 1'b0, 7, 6, 2);
    @(posedge aclk);
    #1;
    check("shift0_done_valid", 32'(resp_valid), 32'h0);
    check("shift0_done_busy", 32'(busy), 32'h0);

    // No-op direction bypasses the shifter.
    set_req(2, 16'hBEEF, 3'd5, 2'b00);
    req_valid = 4'b0100;
    wait_grant("byp2", 2'd2);
    req_valid = '0;
    wait_resp("byp2", 16'hBEEF, 2'd2, 1'b1, 1, 0, 0);
    @(posedge aclk);
    #1;

    // Coefficient 0 shift held under back-pressure for 10 cycles.
    resp_ready = 1'b0;
    set_req(0, 16'h1234, 3'd0, 2'b10);
    req_valid = 4'b0001;
    wait_grant("stall", 2'd0);
    req_valid = 4'b1111;
    wait_resp("stall", 16'h1234, 2'd0, 1'b0, 7, 6, 2);
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      check("stall_valid", 32'(resp_valid), 32'h1);
      check("stall_data", 32'(resp_data), 32'h1234);
      check("stall_id", 32'(resp_id), 32'h0);
      check("stall_ready", 32'(req_ready), 32'h0);
      check("stall_busy", 32'(busy), 32'h1);
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    @(posedge aclk);
    #1;
    check("stall_release", 32'(resp_valid), 32'h0);

    // Move pointer to 2 via requester 1, then 1 and 3 compete: 3 wins.
    set_req(1, 16'h5A5A, 3'd0, 2'b11);
    req_valid = 4'b0010;
    wait_grant("byp1", 2'd1);
    req_valid = '0;
    wait_resp("byp1", 16'h5A5A, 2'd1, 1'b1, 1, 0, 0);
    @(posedge aclk);
    #1;
    set_req(3, 16'h0F0F, 3'd0, 2'b00);
    req_valid = 4'b1010;
    wait_grant("ptr2", 2'd3);
    req_valid = '0;
    wait_resp("ptr2", 16'h0F0F, 2'd3, 1'b1, 1, 0, 0);
    @(posedge aclk);
    #1;

    // All four requesting continuously: order 0,1,2,3,0 from pointer 0.
    set_req(0, 16'h0010, 3'd4, 2'b01);
    set_req(1, 16'h1111, 3'd2, 2'b00);
    set_req(2, 16'h00F0, 3'd3, 2'b10);
    set_req(3, 16'hCAFE, 3'd7, 2'b11);
    req_valid = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_grant("rr", rr_id[t]);
      wait_resp("rr", rr_data[t], rr_id[t], rr_byp[t], rr_byp[t] ? 1 : 7,
                rr_byp[t] ? 0 : 6, rr_byp[t] ? 0 : 2);
    end
    req_valid = '0;
    @(posedge aclk);
    #1;

    // Reset during EXEC of requester 2's transaction (pointer would be 3).
    set_req(2, 16'h4321, 3'd1, 2'b10);
    req_valid = 4'b0100;
    wait_grant("abort", 2'd2);
    req_valid = 4'b1010;
    @(posedge aclk);
    @(posedge aclk);
    #2;
    check("abort_in_exec_en", 32'(sh_enable), 32'h1);
    check("abort_in_exec_wr", 32'(sh_write), 32'h0);
    aresetn = 1'b0;
    #1;
    check("abort_ready", 32'(req_ready), 32'h0);
    check("abort_resp_valid", 32'(resp_valid), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_sh_enable", 32'(sh_enable), 32'h0);
    check("abort_sh_input", 32'(sh_input), 32'h0);
    check("abort_resp_data", 32'(resp_data), 32'h0);
    set_req(1, 16'h00FF, 3'd2, 2'b01);
    repeat (2) begin
      @(negedge aclk);
      check("abort_hold_valid", 32'(resp_valid), 32'h0);
    end
    @(posedge aclk);
    #1 aresetn = 1'b1;
    wait_grant("post_rst", 2'd1);
    req_valid = '0;
    wait_resp("post_rst", 16'hC03F, 2'd1, 1'b0, 7, 6, 2);
    @(posedge aclk);
    #1;
    check("final_valid", 32'(resp_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
